// File: rtl/apu_dpcm_pkg.sv
// apu_dpcm_pkg: shared defaults and clip limit for the DPCM delta unit
package apu_dpcm_pkg;
    localparam int DEF_OUT_W = 7;
    localparam int DEF_STEP  = 2;
    localparam int DEF_BITS  = 8;
    localparam int DEF_DIV_W = 9;
    // Highest counter value that can still take a full upward step without wrapping
    function automatic int up_limit(input int out_w, input int step);
        return (1 << out_w) - 1 - step;
    endfunction
endpackage

// File: rtl/dpcm_delta_unit_if.sv
// dpcm_delta_unit_if: control, sample handshake and output bundle of the delta unit
interface dpcm_delta_unit_if
    import apu_dpcm_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int BITS  = DEF_BITS,
    parameter int DIV_W = DEF_DIV_W
) ();
    logic [DIV_W-1:0] rate_period;
    logic             load_en;
    logic [OUT_W-1:0] load_val;
    logic             smp_valid;
    logic [BITS-1:0]  smp_data;
    logic             smp_ready;
    logic [OUT_W-1:0] dout;
    logic             silence;
    logic             underflow;
    modport master (
        output rate_period, load_en, load_val, smp_valid, smp_data,
        input  smp_ready, dout, silence, underflow
    );
    modport slave (
        input  rate_period, load_en, load_val, smp_valid, smp_data,
        output smp_ready, dout, silence, underflow
    );
endinterface

// File: rtl/dpcm_rate_timer.sv
// dpcm_rate_timer: down-counter producing one tick every (reload+1) clocks
module dpcm_rate_timer
    import apu_dpcm_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             CLK,
    input  logic             nRES,
    input  logic [DIV_W-1:0] i_reload,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_count;
    assign o_tick = (r_count == '0);
    // Count down; at zero fire the tick and reload the period presented right now
    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) r_count <= '0;
        else       r_count <= o_tick ? i_reload : r_count - 1'b1;
endmodule

// File: rtl/dpcm_delta_unit.sv
// dpcm_delta_unit: 1-bit delta decoder with one-entry sample buffer and clipped counter
module dpcm_delta_unit
    import apu_dpcm_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int STEP  = DEF_STEP,
    parameter int BITS  = DEF_BITS,
    parameter int DIV_W = DEF_DIV_W
) (
    input logic         CLK,
    input logic         nRES,
    dpcm_delta_unit_if.slave bus
);
    localparam int CNT_W  = $clog2(BITS);
    localparam int UP_LIM = up_limit(OUT_W, STEP);
    logic             w_tick, w_bit, w_cycle_end, w_take, w_up, w_dn;
    logic [OUT_W-1:0] r_dout, w_dout_next;
    logic [BITS-1:0]  r_shreg, r_buf;
    logic [CNT_W-1:0] r_bitcnt;
    logic             r_full, r_silence, r_underflow;

    dpcm_rate_timer #(.DIV_W(DIV_W)) u_timer (
        .CLK      (CLK),
        .nRES     (nRES),
        .i_reload (bus.rate_period),
        .o_tick   (w_tick)
    );

    assign w_bit       = r_shreg[0];
    assign w_cycle_end = w_tick && (r_bitcnt == '0);
    assign w_take      = bus.smp_valid && !r_full;
    assign w_up        = w_tick && !r_silence && w_bit && (int'(r_dout) <= UP_LIM);
    assign w_dn        = w_tick && !r_silence && !w_bit && (int'(r_dout) >= STEP);
    assign w_dout_next = bus.load_en ? bus.load_val :
                         w_up        ? r_dout + OUT_W'(STEP) :
                         w_dn        ? r_dout - OUT_W'(STEP) : r_dout;

    // Shifter, bit counter and silence advance on ticks; a cycle end refills from the buffer
    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) begin
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_silence <= 1'b1;
        end else if (w_tick) begin
            r_shreg  <= (w_cycle_end && r_full) ? r_buf : r_shreg >> 1;
            r_bitcnt <= w_cycle_end ? CNT_W'(BITS - 1) : r_bitcnt - 1'b1;
            if (w_cycle_end) r_silence <= !r_full;
        end

    // One-entry buffer: filled by the handshake, drained at a cycle end that finds it full
    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) begin
            r_full <= 1'b0;
            r_buf  <= '0;
        end else if (w_take) begin
            r_full <= 1'b1;
            r_buf  <= bus.smp_data;
        end else if (w_cycle_end) begin
            r_full <= 1'b0;
        end

    // Output counter and the underflow pulse for cycles that start without a sample
    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) begin
            r_dout      <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_dout      <= w_dout_next;
            r_underflow <= w_cycle_end && !r_full;
        end

    assign bus.dout      = r_dout;
    assign bus.smp_ready = !r_full;
    assign bus.silence   = r_silence;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_dpcm_delta_unit.sv
// tb_dpcm_delta_unit: vector table plus scoreboard of expected per-tick counter values
module tb_dpcm_delta_unit;
    localparam int OUT_W = 7, STEP = 2, BITS = 8, DIV_W = 9;

    logic CLK = 1'b0;
    logic nRES = 1'b0;
    always #5 CLK = ~CLK;

    dpcm_delta_unit_if #(.OUT_W(OUT_W), .BITS(BITS), .DIV_W(DIV_W)) bus ();
    dpcm_delta_unit #(.OUT_W(OUT_W), .STEP(STEP), .BITS(BITS), .DIV_W(DIV_W)) dut (
        .CLK  (CLK),
        .nRES (nRES),
        .bus  (bus)
    );

    typedef struct {
        logic [OUT_W-1:0] lv;
        logic [BITS-1:0]  data;
        int               fin;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int sb_dout = 0;
    int last;
    int acc;
    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int step_ref(input int d, input bit b);
        if (b) return (d + STEP <= (1 << OUT_W) - 1) ? d + STEP : d;
        return (d >= STEP) ? d - STEP : d;
    endfunction

    task automatic queue_byte(input logic [BITS-1:0] b);
        for (int i = 0; i < BITS; i++) begin
            sb_dout = step_ref(sb_dout, b[i]);
            exp_q.push_back(sb_dout);
        end
    endtask

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_chk(input string name, inout int prev);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d, want <scoreboard empty>", name, int'(bus.dout));
        end else begin
            prev = exp_q.pop_front();
            chk(name, int'(bus.dout), prev);
        end
    endtask

    task automatic do_reset(input int rp);
        @(negedge CLK);
        nRES = 1'b0;
        bus.rate_period = DIV_W'(rp);
        bus.load_en = 1'b0;
        bus.load_val = '0;
        bus.smp_valid = 1'b0;
        bus.smp_data = '0;
        #2;
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_ready", int'(bus.smp_ready), 1);
        chk("rst_silence", int'(bus.silence), 1);
        chk("rst_underflow", int'(bus.underflow), 0);
        @(negedge CLK);
        nRES = 1'b1;
        exp_q.delete();
        sb_dout = 0;
    endtask

    initial begin
        vt[0] = '{7'd126, 8'hFF, 126};
        vt[1] = '{7'd1,   8'h00, 1};
        vt[2] = '{7'd0,   8'hFF, 16};
        vt[3] = '{7'd64,  8'hAA, 64};
        vt[4] = '{7'd10,  8'h0F, 10};
        vt[5] = '{7'd124, 8'h03, 114};
        vt[6] = '{7'd3,   8'hF0, 9};
        vt[7] = '{7'd125, 8'h01, 113};
        vt[8] = '{7'd2,   8'h00, 0};

        // Slow rate: first tick is a silent cycle end that also captures the byte
        do_reset(3);
        bus.smp_valid = 1'b1;
        bus.smp_data = 8'hFF;
        edge1();
        bus.smp_valid = 1'b0;
        chk("a_uf_first", int'(bus.underflow), 1);
        chk("a_sil_first", int'(bus.silence), 1);
        chk("a_ready_full", int'(bus.smp_ready), 0);
        queue_byte(8'hFF);
        for (int t = 0; t < 8; t++) repeat (4) edge1();
        chk("a_sil_play", int'(bus.silence), 0);
        chk("a_ready_drained", int'(bus.smp_ready), 1);
        chk("a_dout_pre", int'(bus.dout), 0);
        last = 0;
        for (int t = 0; t < 8; t++) begin
            repeat (3) begin
                edge1();
                chk("a_hold", int'(bus.dout), last);
            end
            edge1();
            tick_chk("a_tick", last);
        end
        chk("a_sil_end", int'(bus.silence), 1);
        chk("a_uf_end", int'(bus.underflow), 1);

        // Table: load a start value, play one byte at one tick per clock
        for (int i = 0; i < 9; i++) begin
            do_reset(0);
            bus.load_en = 1'b1;
            bus.load_val = vt[i].lv;
            bus.smp_valid = 1'b1;
            bus.smp_data = vt[i].data;
            edge1();
            bus.load_en = 1'b0;
            bus.smp_valid = 1'b0;
            sb_dout = int'(vt[i].lv);
            last = sb_dout;
            queue_byte(vt[i].data);
            repeat (8) edge1();
            chk("v_hold", int'(bus.dout), int'(vt[i].lv));
            chk("v_sil_play", int'(bus.silence), 0);
            repeat (8) begin
                edge1();
                tick_chk("v_tick", last);
            end
            chk("v_final", int'(bus.dout), vt[i].fin);
            chk("v_sil_end", int'(bus.silence), 1);
        end

        // Starved: three silent cycle ends in 20 clocks, counter untouched
        do_reset(0);
        bus.load_en = 1'b1;
        bus.load_val = 7'd40;
        edge1();
        bus.load_en = 1'b0;
        acc = int'(bus.underflow);
        repeat (19) begin
            edge1();
            acc += int'(bus.underflow);
            if (bus.silence !== 1'b1) acc += 100;
        end
        chk("u_pulses", acc, 3);
        chk("u_dout", int'(bus.dout), 40);

        // Back-pressure: second byte refused while full, taken once the buffer drains
        do_reset(0);
        bus.smp_valid = 1'b1;
        bus.smp_data = 8'hAA;
        edge1();
        queue_byte(8'hAA);
        bus.smp_data = 8'h55;
        acc = 0;
        repeat (7) begin
            edge1();
            acc += int'(bus.smp_ready);
        end
        chk("b_ready_full", acc, 0);
        edge1();
        chk("b_ready_after_end", int'(bus.smp_ready), 1);
        edge1();
        bus.smp_valid = 1'b0;
        chk("b_ready_taken", int'(bus.smp_ready), 0);
        last = 0;
        tick_chk("b_tick", last);
        queue_byte(8'h55);
        repeat (15) begin
            edge1();
            tick_chk("b_tick", last);
        end
        chk("b_sil_end", int'(bus.silence), 1);

        // Direct load on a tick whose bit is 1 overrides the step
        do_reset(0);
        bus.smp_valid = 1'b1;
        bus.smp_data = 8'hFF;
        edge1();
        bus.smp_valid = 1'b0;
        repeat (8) edge1();
        bus.load_en = 1'b1;
        bus.load_val = 7'd64;
        edge1();
        bus.load_en = 1'b0;
        chk("l_load", int'(bus.dout), 64);
        edge1();
        chk("l_next", int'(bus.dout), step_ref(64, 1'b1));
        bus.smp_valid = 1'b1;
        bus.smp_data = 8'hFF;
        edge1();
        bus.smp_valid = 1'b0;
        chk("l_buf_full", int'(bus.smp_ready), 0);

        // Mid-cycle reset: buffered byte must be gone, first cycle end is silent
        do_reset(0);
        edge1();
        chk("r_uf_first", int'(bus.underflow), 1);
        chk("r_sil_first", int'(bus.silence), 1);
        repeat (8) edge1();
        chk("r_sil_second", int'(bus.silence), 1);
        chk("r_uf_second", int'(bus.underflow), 1);
        chk("r_dout", int'(bus.dout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dpcm_delta_unit.md
DPCM_DELTA_UNIT -- requirements
Module: dpcm_delta_unit

Interface
REQ-001 SHALL have parameter OUT_W, default 7, delta-counter output width.
REQ-002 SHALL have parameter STEP, default 2, increment/decrement per sample bit.
REQ-003 SHALL have parameter BITS, default 8, sample bits per output cycle (power of two, >=2).
REQ-004 SHALL have parameter DIV_W, default 9, rate-timer width.
REQ-005 SHALL have port CLK  in  1  the only clock; all state on rising edge.
REQ-006 SHALL have port nRES  in  1  reset; asynchronous and active-low.
REQ-007 SHALL have port rate_period  in  DIV_W  tick interval minus one, in CLK cycles.
REQ-008 SHALL have port load_en  in  1  direct load of delta counter.
REQ-009 SHALL have port load_val  in  OUT_W  value for direct load.
REQ-010 SHALL have port smp_valid  in  1  sample byte offered.
REQ-011 SHALL have port smp_data  in  BITS  sample byte, LSB consumed first.
REQ-012 SHALL have port smp_ready  out  1  sample buffer empty, can accept.
REQ-013 SHALL have port dout  out  OUT_W  delta counter value.
REQ-014 SHALL have port silence  out  1  current output cycle has no sample.
REQ-015 SHALL have port underflow  out  1  one-CLK pulse, cycle started with empty buffer.

Function
REQ-016 Rate timer SHALL decrement each CLK; at 0 it SHALL reload rate_period and assert an internal tick that CLK; rate_period=0 gives a tick every CLK.
REQ-017 Sample buffer SHALL be one entry; smp_ready = not full; transfer occurs on CLK where smp_valid and smp_ready are both 1.
REQ-018 On tick with silence=0: bit=shreg[0]; bit=1 and dout <= 2^OUT_W-1-STEP: dout += STEP; bit=0 and dout >= STEP: dout -= STEP; otherwise dout holds (clip, no wrap).
REQ-019 On tick shreg SHALL shift right one, zero fill; bitcnt SHALL decrement.
REQ-020 On tick with bitcnt=0 (cycle end), after the REQ-018 update: bitcnt <= BITS-1; if buffer full, shreg <= buffer, buffer empty, silence <= 0; else silence <= 1 and underflow pulses for that CLK.
REQ-021 A write and a cycle-end on the same CLK with buffer empty: the cycle-end SHALL see empty (silence, underflow); the write SHALL land in the buffer.
REQ-022 With buffer full at cycle end, smp_ready SHALL read 1 from the following CLK.
REQ-023 load_en SHALL set dout <= load_val, overriding any REQ-018 update in the same CLK; shift, bitcnt, buffer and silence behave as if load_en were 0.
REQ-024 rate_period changes SHALL take effect at the next reload only.
REQ-025 Latency: dout changes on the CLK edge that carries the tick; no pipeline stage.

Reset
REQ-026 While nRES=0: dout=0, timer=0, bitcnt=0, shreg=0, buffer empty, smp_ready=1, silence=1, underflow=0.
REQ-027 Reset asserted mid-cycle SHALL discard buffer and shreg immediately; first tick after release is a silent cycle end (reload path of REQ-020).

Structure
REQ-028 Parameter defaults and the clip-limit expression SHALL live in shared package apu_dpcm_pkg.
REQ-029 Rate timer SHALL be sub-module dpcm_rate_timer (DIV_W parameter, reload input, tick output).
REQ-030 bitcnt width SHALL be $clog2(BITS).

Verification (OUT_W=7, STEP=2, BITS=8)
REQ-031 Reset, rate_period=3, push 0xFF before first tick -> tick every 4 CLK; first tick loads shreg; next 8 ticks dout 2,4,...,16; silence=0.
REQ-032 load_val=126, push 0xFF -> dout holds 126; load_val=1, push 0x00 -> dout holds 1 (both clip).
REQ-033 No sample pushed, 3 cycle ends -> silence=1, exactly 3 underflow pulses, dout constant.
REQ-034 Push 0xAA then 0x55 while full -> smp_ready=0, second offer not taken; smp_ready=1 the CLK after cycle end; 0x55 accepted on re-offer.
REQ-035 load_en with load_val=64 on a tick CLK with bit=1 -> dout=64, next tick dout=66 or 62 per next bit.
REQ-036 nRES pulsed low mid-cycle between CLK edges -> all outputs at REQ-026 values immediately, without waiting for CLK.
